// File: rtl/dg_ctl_pkg.sv
// dg_ctl_pkg: shared types, constants and helpers for the data-generator run controller
//   state_e  : run FSM states
//   PORT_W   : config port-index width for the default port count
//   popcount : number of set bits in a (zero-extended) vector
package dg_ctl_pkg;
    typedef enum logic [2:0] {IDLE, ARM, RUN, DRAIN, DONE} state_e;
    localparam int NUM_PORT_DEF = 16;
    localparam int PORT_W = $clog2(NUM_PORT_DEF);
    localparam int POP_MAX = 256;
    function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
        popcount = 0;
        for (int i = 0; i < POP_MAX; i++) popcount += 32'(v[i]);
    endfunction
endpackage

// File: rtl/dg_ctl_if.sv
// dg_ctl_if: generator-side bundle between the run controller and the data generators
//   o_fetch_n : per-port fetch count, port p at [p*RAM_ADDR_W +: RAM_ADDR_W]
//   i_sop/i_vld/i_eop : per-port packet framing from the generators
//   master = generator side, slave = controller side
interface dg_ctl_if #(
    parameter int NUM_PORT   = 16,
    parameter int RAM_ADDR_W = 10
);
    logic [NUM_PORT*RAM_ADDR_W-1:0] o_fetch_n;
    logic [NUM_PORT-1:0]            i_sop;
    logic [NUM_PORT-1:0]            i_vld;
    logic [NUM_PORT-1:0]            i_eop;
    modport master (output i_sop, i_vld, i_eop, input o_fetch_n);
    modport slave (input i_sop, i_vld, i_eop, output o_fetch_n);
endinterface

// File: rtl/dg_port_mon.sv
// dg_port_mon: per-port framing monitor with packet counter, in-packet flag and sticky error
//   i_sop/i_vld/i_eop : port stream, i_act : monitor enabled, i_clr : clear all state
//   i_cfg             : packets expected on this port
//   o_in_pkt          : in-packet flag including this cycle's beat
//   o_pkt_done        : count (including this cycle's eop) has reached i_cfg
//   o_proto_err       : sticky framing error, o_eop_ev : valid eop this cycle
module dg_port_mon #(
    parameter int RAM_ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_sop,
    input  logic                  i_vld,
    input  logic                  i_eop,
    input  logic                  i_act,
    input  logic                  i_clr,
    input  logic [RAM_ADDR_W-1:0] i_cfg,
    output logic                  o_in_pkt,
    output logic                  o_pkt_done,
    output logic                  o_proto_err,
    output logic                  o_eop_ev
);
    logic                  in_pkt_q, in_pkt_d, err_q, err_d, beat, ev_sop, bad;
    logic [RAM_ADDR_W-1:0] cnt_q, cnt_d;

    // Next-state values feed done/in-packet so the FSM can react in the same cycle as the eop.
    always_comb begin
        beat       = i_act & i_vld;
        ev_sop     = beat & i_sop & ~i_eop;
        o_eop_ev   = beat & i_eop;
        bad        = in_pkt_q ? (beat & i_sop) : (beat & i_eop & ~i_sop);
        in_pkt_d   = i_clr ? 1'b0 : ev_sop ? 1'b1 : o_eop_ev ? 1'b0 : in_pkt_q;
        cnt_d      = i_clr ? '0 : (o_eop_ev && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        err_d      = ~i_clr & (err_q | bad);
        o_in_pkt   = in_pkt_d;
        o_pkt_done = cnt_d >= i_cfg;
        o_proto_err = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_pkt_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            in_pkt_q <= in_pkt_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/dg_ctl.sv
// dg_ctl: run controller for a bank of data-generator ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_cfg_*           : per-port fetch-count config write (IDLE only)
//   i_start, i_abort  : run control pulses
//   gen (slave)       : fetch counts out, sop/vld/eop in
//   o_busy, o_done, o_timeout, o_proto_err, o_pkt_total : run status
module dg_ctl
    import dg_ctl_pkg::*;
#(
    parameter int NUM_PORT   = 16,
    parameter int RAM_ADDR_W = 10,
    parameter int CNT_W      = 16,
    parameter int TO_W       = 20
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_cfg_we,
    input  logic [$clog2(NUM_PORT)-1:0] i_cfg_port,
    input  logic [RAM_ADDR_W-1:0]       i_cfg_fetch_n,
    input  logic                        i_start,
    input  logic                        i_abort,
    dg_ctl_if.slave                     gen,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_timeout,
    output logic [NUM_PORT-1:0]         o_proto_err,
    output logic [CNT_W-1:0]            o_pkt_total
);
    localparam int PW = $clog2(NUM_PORT);

    state_e                         state_q, state_d;
    logic [RAM_ADDR_W-1:0]          cfg_q [NUM_PORT];
    logic [NUM_PORT*RAM_ADDR_W-1:0] fetch_q, fetch_d;
    logic [TO_W-1:0]                to_q, to_d;
    logic [CNT_W-1:0]               tot_q, tot_d;
    logic [CNT_W:0]                 tot_sum;
    logic                           tmo_q, tmo_d, tmo_set, act, clr, to_hit;
    logic [NUM_PORT-1:0]            in_pkt, pkt_done, eop_ev;

    for (genvar p = 0; p < NUM_PORT; p++) begin : g_mon
        dg_port_mon #(.RAM_ADDR_W(RAM_ADDR_W)) u_mon (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_sop       (gen.i_sop[p]),
            .i_vld       (gen.i_vld[p]),
            .i_eop       (gen.i_eop[p]),
            .i_act       (act),
            .i_clr       (clr),
            .i_cfg       (cfg_q[p]),
            .o_in_pkt    (in_pkt[p]),
            .o_pkt_done  (pkt_done[p]),
            .o_proto_err (o_proto_err[p]),
            .o_eop_ev    (eop_ev[p])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        tmo_set = 1'b0;
        to_hit  = &to_q;
        case (state_q)
            IDLE:  if (i_start) state_d = ARM;
            ARM:   state_d = RUN;
            RUN: begin
                if (&pkt_done) state_d = DONE;
                else if (to_hit) begin
                    state_d = DONE;
                    tmo_set = 1'b1;
                end else if (i_abort) state_d = DRAIN;
            end
            DRAIN: begin
                if (!(|in_pkt)) state_d = DONE;
                else if (to_hit) begin
                    state_d = DONE;
                    tmo_set = 1'b1;
                end
            end
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_busy = state_q inside {ARM, RUN, DRAIN};
        o_done = state_q == DONE;
        act    = state_q inside {RUN, DRAIN};
        clr    = state_q == ARM;
    end

    // Fetch counts are loaded on the edge entering RUN so generators see them from the first RUN cycle.
    always_comb begin
        for (int p = 0; p < NUM_PORT; p++)
            fetch_d[p*RAM_ADDR_W +: RAM_ADDR_W] = (state_d == RUN) ? cfg_q[p] : '0;
        to_d    = clr ? '0 : act ? ((|gen.i_vld) ? '0 : to_q + 1'b1) : to_q;
        tmo_d   = ~clr & (tmo_q | tmo_set);
        tot_sum = {1'b0, tot_q} + (CNT_W+1)'(popcount(POP_MAX'(eop_ev)));
        tot_d   = clr ? '0 : act ? (tot_sum[CNT_W] ? '1 : tot_sum[CNT_W-1:0]) : tot_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_q <= '0;
            to_q    <= '0;
            tmo_q   <= 1'b0;
            tot_q   <= '0;
            cfg_q   <= '{default: '0};
        end else begin
            fetch_q <= fetch_d;
            to_q    <= to_d;
            tmo_q   <= tmo_d;
            tot_q   <= tot_d;
            for (int p = 0; p < NUM_PORT; p++)
                if (i_cfg_we && state_q == IDLE && i_cfg_port == PW'(p)) cfg_q[p] <= i_cfg_fetch_n;
        end
    end

    assign gen.o_fetch_n = fetch_q;
    assign o_timeout     = tmo_q;
    assign o_pkt_total   = tot_q;
endmodule

// File: tb/tb_dg_ctl.sv
// tb_dg_ctl: directed self-checking bench for dg_ctl with a cycle-level reference model
module tb_dg_ctl;
    import dg_ctl_pkg::*;
    localparam int NP = 16, AW = 10, CW = 16, TW = 4;

    logic              clk = 1'b0, rst_n = 1'b1, en = 1'b0;
    logic              cfg_we = 1'b0, start = 1'b0, abort_r = 1'b0;
    logic [PORT_W-1:0] cfg_port = '0;
    logic [AW-1:0]     cfg_val = '0;
    logic              busy, done, tmo;
    logic [NP-1:0]     perr;
    logic [CW-1:0]     total;
    int                checks = 0, fails = 0, n;

    dg_ctl_if #(.NUM_PORT(NP), .RAM_ADDR_W(AW)) gen_if ();

    dg_ctl #(.NUM_PORT(NP), .RAM_ADDR_W(AW), .CNT_W(CW), .TO_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .i_cfg_we(cfg_we), .i_cfg_port(cfg_port),
        .i_cfg_fetch_n(cfg_val), .i_start(start), .i_abort(abort_r), .gen(gen_if),
        .o_busy(busy), .o_done(done), .o_timeout(tmo), .o_proto_err(perr), .o_pkt_total(total)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0..4 = idle, arm, run, drain, done.
    int               m_ph, m_cnt [NP], m_cfg [NP], m_tot, m_to;
    bit               m_inp [NP], m_tmo, alldone, anyin, hit;
    logic [NP-1:0]    m_err;
    logic [NP*AW-1:0] m_fetch;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = 0; m_tot = 0; m_to = 0; m_tmo = 0; m_err = '0; m_fetch = '0;
            for (int p = 0; p < NP; p++) begin m_cnt[p] = 0; m_cfg[p] = 0; m_inp[p] = 0; end
        end else begin
            case (m_ph)
                0: begin
                    if (cfg_we) m_cfg[cfg_port] = int'(cfg_val);
                    if (start) m_ph = 1;
                end
                1: begin
                    m_tot = 0; m_to = 0; m_tmo = 0; m_err = '0;
                    for (int p = 0; p < NP; p++) begin m_cnt[p] = 0; m_inp[p] = 0; end
                    m_ph = 2;
                end
                2, 3: begin
                    hit = (m_to == (1 << TW) - 1);
                    for (int p = 0; p < NP; p++) if (gen_if.i_vld[p]) begin
                        if (gen_if.i_sop[p] && m_inp[p]) m_err[p] = 1'b1;
                        if (gen_if.i_eop[p] && !gen_if.i_sop[p] && !m_inp[p]) m_err[p] = 1'b1;
                        if (gen_if.i_eop[p]) begin
                            if (m_cnt[p] < (1 << AW) - 1) m_cnt[p]++;
                            if (m_tot < (1 << CW) - 1) m_tot++;
                            m_inp[p] = 0;
                        end else if (gen_if.i_sop[p]) m_inp[p] = 1;
                    end
                    m_to = (|gen_if.i_vld) ? 0 : m_to + 1;
                    alldone = 1; anyin = 0;
                    for (int p = 0; p < NP; p++) begin
                        if (m_cnt[p] < m_cfg[p]) alldone = 0;
                        if (m_inp[p]) anyin = 1;
                    end
                    if (m_ph == 2) begin
                        if (alldone) m_ph = 4;
                        else if (hit) begin m_ph = 4; m_tmo = 1; end
                        else if (abort_r) m_ph = 3;
                    end else begin
                        if (!anyin) m_ph = 4;
                        else if (hit) begin m_ph = 4; m_tmo = 1; end
                    end
                end
                default: m_ph = 0;
            endcase
            for (int p = 0; p < NP; p++) m_fetch[p*AW +: AW] = (m_ph == 2) ? AW'(m_cfg[p]) : '0;
        end
    end

    task automatic check(input string nm, input logic [159:0] a, input logic [159:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    always @(negedge clk) if (en) begin
        check("m_busy", busy, m_ph inside {1, 2, 3});
        check("m_done", done, m_ph == 4);
        check("m_timeout", tmo, m_tmo);
        check("m_proto_err", perr, m_err);
        check("m_pkt_total", total, m_tot);
        check("m_fetch_n", gen_if.o_fetch_n, m_fetch);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int p, input int v);
        cfg_we = 1'b1; cfg_port = PORT_W'(p); cfg_val = AW'(v);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic beat(input logic [NP-1:0] s, input logic [NP-1:0] v, input logic [NP-1:0] e, input logic ab = 1'b0);
        gen_if.i_sop = s; gen_if.i_vld = v; gen_if.i_eop = e; abort_r = ab;
        tick();
        gen_if.i_sop = '0; gen_if.i_vld = '0; gen_if.i_eop = '0; abort_r = 1'b0;
    endtask

    // Leaves the bench #1 into the first RUN cycle.
    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    function automatic logic [AW-1:0] fslice(input int p);
        return gen_if.o_fetch_n[p*AW +: AW];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        gen_if.i_sop = '0; gen_if.i_vld = '0; gen_if.i_eop = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_total", total, 0);
        check("rst_fetch", gen_if.o_fetch_n, 0);
        // basic run: port0 three 2-beat packets, port5 one single-beat packet
        cfg(0, 3); cfg(5, 1); go();
        check("run1_fetch0", fslice(0), 3);
        check("run1_fetch5", fslice(5), 1);
        beat(16'h0021, 16'h0021, 16'h0020);
        beat(16'h0000, 16'h0001, 16'h0001);
        beat(16'h0001, 16'h0001, 16'h0000);
        beat(16'h0000, 16'h0001, 16'h0001);
        beat(16'h0001, 16'h0001, 16'h0000);
        beat(16'h0000, 16'h0001, 16'h0001);
        check("run1_done", done, 1);
        check("run1_total", total, 4);
        tick();
        check("run1_idle_busy", busy, 0);
        // all-zero config: ARM + RUN busy, then DONE
        cfg(0, 0); cfg(5, 0);
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (busy && n < 20) begin n++; tick(); end
        check("zero_busy_cycles", n, 2);
        check("zero_done", done, 1);
        check("zero_total", total, 0);
        tick();
        // simultaneous eops and a double sop on port1
        cfg(1, 2); cfg(2, 1); go();
        beat(16'h0006, 16'h0006, 16'h0000);
        beat(16'h0000, 16'h0006, 16'h0006);
        check("dual_eop_total", total, 2);
        check("dual_no_err", perr, 0);
        beat(16'h0002, 16'h0002, 16'h0000);
        beat(16'h0002, 16'h0002, 16'h0000);
        beat(16'h0000, 16'h0002, 16'h0002);
        check("err_port1", perr, 16'h0002);
        check("err_total", total, 3);
        check("err_done", done, 1);
        tick();
        // abort mid-packet, drain until eop
        cfg(1, 0); cfg(2, 0); cfg(0, 4); go();
        beat(16'h0001, 16'h0001, 16'h0000);
        beat(16'h0000, 16'h0001, 16'h0001);
        beat(16'h0001, 16'h0001, 16'h0000);
        beat(16'h0000, 16'h0001, 16'h0001);
        beat(16'h0001, 16'h0001, 16'h0000, 1'b1);
        check("abort_fetch", gen_if.o_fetch_n, 0);
        tick(); tick();
        check("drain_busy", busy, 1);
        check("drain_no_done", done, 0);
        beat(16'h0000, 16'h0001, 16'h0001);
        check("drain_done", done, 1);
        check("drain_total", total, 3);
        check("drain_tmo", tmo, 0);
        tick();
        // stall timeout with a dropped config write during RUN
        cfg(0, 2); go();
        n = 0;
        cfg(0, 7); n++;
        while (!done && n < 40) begin tick(); n++; end
        check("to_cycles", n, 16);
        check("to_flag", tmo, 1);
        tick();
        check("to_sticky", tmo, 1);
        go();
        check("cfg_kept", fslice(0), 2);
        beat(16'h0001, 16'h0001, 16'h0001);
        beat(16'h0001, 16'h0001, 16'h0001);
        check("run5_done", done, 1);
        check("run5_tmo_clr", tmo, 0);
        check("run5_total", total, 2);
        tick();
        // asynchronous reset mid-run
        cfg(0, 3); go();
        beat(16'h0001, 16'h0001, 16'h0000);
        beat(16'h0000, 16'h0001, 16'h0001);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_total", total, 0);
        check("arst_fetch", gen_if.o_fetch_n, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        cfg(3, 1); go();
        check("post_fetch0", fslice(0), 0);
        check("post_fetch3", fslice(3), 1);
        beat(16'h0008, 16'h0008, 16'h0008);
        check("post_done", done, 1);
        check("post_total", total, 1);
        tick(); tick();
        en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/dg_ctl.md
Name: dg_ctl

Overview:
Run controller for a bank of NUM_PORT data-generator wrappers. It holds a per-port fetch count configuration and releases it to the generators only while a run is active. It monitors each port's sop/vld/eop stream to count completed packets, detect framing errors and detect stalls. It reports busy, done and timeout to the test-harness top level, which sits above the generators and the cache input ports.

Parameters:
NUM_PORT, 16, number of generator ports controlled
RAM_ADDR_W, 10, width of per-port fetch count (matches generator descriptor RAM address width)
CNT_W, 16, width of aggregate packet counter
TO_W, 20, width of stall-timeout counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_cfg_we  in  1  config write strobe
i_cfg_port  in  $clog2(NUM_PORT)  port index for config write
i_cfg_fetch_n  in  RAM_ADDR_W  packets to fetch for that port
i_start  in  1  start-run pulse
i_abort  in  1  abort-run pulse
o_fetch_n  out  NUM_PORT*RAM_ADDR_W  per-port fetch count to generators, port p at [p*RAM_ADDR_W +: RAM_ADDR_W]
i_sop  in  NUM_PORT  generator sop per port
i_vld  in  NUM_PORT  generator vld per port
i_eop  in  NUM_PORT  generator eop per port
o_busy  out  1  run in progress
o_done  out  1  one-cycle run-complete pulse
o_timeout  out  1  sticky: last run ended by stall timeout
o_proto_err  out  NUM_PORT  sticky per-port framing error
o_pkt_total  out  CNT_W  packets completed in current/last run, saturating

Behaviour:
- Clock and reset: clk is the only clock. rst_n is asynchronous and active-low.
- Reset values:
  - All outputs are 0.
  - Config registers are 0.
  - FSM is in IDLE.
  - All counters are 0.
- Config: i_cfg_we writes cfg[i_cfg_port] <= i_cfg_fetch_n. Writes are accepted only in IDLE and silently dropped otherwise. An out-of-range port index is dropped.
- FSM states: IDLE, ARM, RUN, DRAIN, DONE.
- IDLE:
  - o_fetch_n = 0 on all ports.
  - i_start moves the FSM to ARM. i_abort is ignored.
  - If i_start and i_abort are both asserted, start wins.
- ARM (1 cycle):
  - Clear per-port packet counters, in-packet flags, o_proto_err, o_timeout, o_pkt_total and the timeout counter.
  - Next state is RUN.
- RUN:
  - o_fetch_n = cfg registers, registered, so it is visible from the first RUN cycle.
  - A port is done when its packet count == cfg[p]. A port with cfg 0 is done immediately.
  - When all ports are done, go to DONE. With an all-zero config, RUN lasts exactly 1 cycle.
  - i_abort goes to DRAIN.
  - If the timeout counter reaches all-ones, set o_timeout and go to DONE.
- DRAIN:
  - o_fetch_n = 0.
  - Go to DONE when all in-packet flags are clear, or on timeout (which also sets o_timeout).
- DONE (1 cycle): o_done = 1, then go to IDLE.
- o_busy = 1 in ARM, RUN and DRAIN; otherwise 0.
- Per-port monitor, active in RUN and DRAIN; events count only when vld is asserted:
  - sop & vld & !eop: sets the in-packet flag. If the flag is already set, that is an error.
  - eop & vld & !sop: clears the flag and increments the packet count. If the flag is clear, that is an error.
  - sop & eop & vld in the same cycle: a single-beat packet, legal only when the flag is clear. It increments the count and leaves the flag clear.
  - sop or eop without vld is ignored.
  - An error sets o_proto_err[p] (sticky until the next ARM). The count still updates on eop.
- Per-port counter: RAM_ADDR_W bits, saturating. Eops beyond cfg[p] are counted but do not undo done.
- o_pkt_total increments by the popcount of valid eops across all ports in the same cycle. It saturates at 2^CNT_W-1.
- Timeout counter: counts in RUN and DRAIN, and resets to 0 in any cycle where any i_vld bit is set.
- Events in IDLE, ARM and DONE are ignored, and counters hold.
- Reset mid-run: the asynchronous return to reset values applies, including o_fetch_n = 0.

Decomposition:
- Package dg_ctl_pkg holds:
  - FSM state enum {IDLE, ARM, RUN, DRAIN, DONE}
  - localparam PORT_W = $clog2(NUM_PORT)
  - a popcount function
- Sub-module dg_port_mon is instantiated NUM_PORT times. Per port it contains:
  - inputs: sop/vld/eop, run-active, clear, cfg
  - outputs: in_pkt, pkt_done, proto_err, eop_ev
  - it holds the per-port packet counter, in-packet flag and sticky error.

Test Plan:
- Config port0=3 and port5=1, others 0, then pulse start. Generate 3 packets on port0 and 1 on port5 -> o_fetch_n slices read 3 and 1 from RUN entry; o_done pulses 1 cycle after the last eop; o_pkt_total=4; o_busy low after DONE.
- All cfg 0, then start -> o_busy high for exactly 2 cycles (ARM, RUN), o_done on the 3rd cycle, o_pkt_total=0.
- Ports 1 and 2 issue eop in the same cycle -> o_pkt_total increments by 2 in one cycle; sop without a preceding eop on port1 -> o_proto_err[1]=1, other bits 0.
- cfg port0=4; abort mid-packet after 2 packets -> o_fetch_n=0 next cycle; DRAIN holds until eop; o_done pulses; o_pkt_total=3; o_timeout=0.
- cfg port0=2 with no traffic and TO_W reduced to 4 -> o_timeout=1 and o_done 16 cycles after RUN entry. Config write during the run is dropped (read back unchanged next run).
- Assert rst_n low mid-RUN -> all outputs 0 asynchronously; FSM in IDLE; a subsequent start with fresh config completes normally.
